spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DW, default 12, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, number of flops in each input synchronizer (minimum 2).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk, idle low.
REQ-006 cs  input  1  chip select, active-low, asynchronous to clk.
REQ-007 mosi  input  1  serial data, LSB first, changed by the master on sclk rising edge.
REQ-008 dout  output  DW  last complete received word.
REQ-009 done  output  1  one-clk pulse: dout updated with a new word.
REQ-010 busy  output  1  high while a frame is in progress (state RECV or HOLD).
REQ-011 frame_err  output  1  one-clk pulse: cs deasserted before DW bits were received.

Function
REQ-012 sclk, cs and mosi SHALL each pass through a SYNC_STAGES flop synchronizer of equal depth before use.
REQ-013 A synchronized sclk falling edge (sampled 1 then 0 on consecutive clks) SHALL be the only bit-sample event; mosi SHALL be sampled from the synchronized value aligned with that edge.
REQ-014 The FSM SHALL have the states IDLE, RECV and HOLD.
REQ-015 IDLE -> RECV when synchronized cs is low; the bit counter SHALL clear to 0 on entry.
REQ-016 In RECV, each sample event SHALL write the sampled bit to shift[count] (LSB first) and increment count.
REQ-017 On the sample event with count == DW-1, the FSM SHALL go to HOLD, load dout with the full word, and assert done on the next clk.
REQ-018 Latency: done SHALL rise exactly SYNC_STAGES+2 clks after the physical sclk falling edge of the final bit.
REQ-019 In HOLD, further sclk edges SHALL be ignored; HOLD -> IDLE when synchronized cs is high.
REQ-020 Synchronized cs high in RECV SHALL cause RECV -> IDLE with a one-clk frame_err pulse; dout SHALL be unchanged and done SHALL NOT assert.
REQ-021 When a cs rise and a sample event coincide in RECV, the cs rise SHALL win and the sample SHALL be discarded.
REQ-022 The count SHALL be sized ceil(log2(DW+1)) bits and SHALL never wrap; sample events with count == DW SHALL be ignored.
REQ-023 The correct-sampling requirement for the bench is sclk high and low phases of at least SYNC_STAGES+2 clk periods each.

Reset
REQ-024 While rst_n is low: state=IDLE, count=0, shift=0, dout=0, done=0, busy=0, frame_err=0, all synchronizer flops set (sclk=0, cs=1, mosi=0).
REQ-025 Reset asserted mid-frame SHALL abort the frame without done or frame_err; after release the block SHALL wait for cs high, then a new cs low, before receiving.

Configuration
REQ-026 Macro SPI_SLV_OVERRUN_EN.
REQ-027 With SPI_SLV_OVERRUN_EN defined, the block SHALL add the input rd_ack (1 bit) and the outputs valid (1 bit) and overrun (1 bit).
REQ-028 valid SHALL be set together with done and SHALL clear on the clk after rd_ack is sampled high.
REQ-029 A frame completing while valid=1 SHALL leave dout unchanged and set overrun; overrun SHALL be sticky until rd_ack.
REQ-030 rd_ack and a completion in the same clk SHALL clear the old word and accept the new one, setting valid=1 and overrun=0.
REQ-031 Without SPI_SLV_OVERRUN_EN, these ports SHALL NOT exist and every completed frame SHALL overwrite dout.

Verification
REQ-032 Frame 12'hA5C, sclk half-period 11 clks -> dout=12'hA5C, exactly one done pulse, frame_err never asserted.
REQ-033 Back-to-back frames 12'h001 then 12'hFFF, with cs high for one sclk period between them -> two done pulses, with dout 12'h001 then 12'hFFF.
REQ-034 cs raised after 5 bits of 12'h3C3 -> one frame_err pulse, no done, dout holds its previous value, busy low afterwards.
REQ-035 rst_n pulsed low after 6 bits -> all outputs 0, then a full 12'h5A5 frame -> dout=12'h5A5 with one done pulse.
REQ-036 With SPI_SLV_OVERRUN_EN defined: frames 12'h111 then 12'h222 without rd_ack -> dout=12'h111, valid=1, overrun=1; then rd_ack -> valid=0, overrun=0.
REQ-037 Extra sclk toggles in HOLD before cs rises -> dout unchanged, no second done pulse.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: bus bundle for the SPI receive slave.
// The slave modport is used by spi_slave_rx; the master modport by whatever
// drives the serial lines and consumes the received words.
// When SPI_SLV_OVERRUN_EN is defined the bundle also carries rd_ack, valid
// and overrun for the read-acknowledge / overrun-protection mode.
interface spi_slave_rx_if #(
    parameter int unsigned DW = 12
);
    // serial side (asynchronous to the system clock)
    logic          sclk;
    logic          cs;
    logic          mosi;

    // parallel side (system clock domain)
    logic [DW-1:0] dout;
    logic          done;
    logic          busy;
    logic          frame_err;

`ifdef SPI_SLV_OVERRUN_EN
    logic          rd_ack;
    logic          valid;
    logic          overrun;
`endif

    modport slave (
        input  sclk,
        input  cs,
        input  mosi,
`ifdef SPI_SLV_OVERRUN_EN
        input  rd_ack,
        output valid,
        output overrun,
`endif
        output dout,
        output done,
        output busy,
        output frame_err
    );

    modport master (
        output sclk,
        output cs,
        output mosi,
`ifdef SPI_SLV_OVERRUN_EN
        output rd_ack,
        input  valid,
        input  overrun,
`endif
        input  dout,
        input  done,
        input  busy,
        input  frame_err
    );

endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI receive-only slave, LSB first, sampled on sclk falling edge.
// sclk, cs and mosi are resynchronised into clk with equal-depth synchronizers;
// a frame of DW bits is collected into a shift register and presented on dout
// with a one-clk done pulse. Early cs deassertion gives a frame_err pulse.
// Optional feature: define SPI_SLV_OVERRUN_EN to add rd_ack/valid/overrun,
// which protect an unread word from being overwritten by the next frame.
module spi_slave_rx #(
    parameter int unsigned DW          = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_slave_rx_if.slave  bus
);

    // synchronizer depth never drops below two flops
    localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // bit counter must reach DW without wrapping
    localparam int unsigned CW = $clog2(DW + 1);
    // width needed to index one bit of the word
    localparam int unsigned IW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    // synchronizer chains; bit [SS-1] is the synchronised value
    logic [SS-1:0] sclk_sync_q;
    logic [SS-1:0] cs_sync_q;
    logic [SS-1:0] mosi_sync_q;
    // fills with ones after reset: marks when the chains hold real pin data
    logic [SS-1:0] vld_sync_q;

    logic          sclk_s;
    logic          cs_s;
    logic          mosi_s;
    logic          sync_vld;

    logic          sclk_prev_q;
    logic          fall_q;
    logic          bit_q;

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] dout_q,  dout_d;
    logic          done_q,  done_d;
    logic          ferr_q,  ferr_d;

    logic [DW-1:0] word_c;
    logic          complete_c;

`ifdef SPI_SLV_OVERRUN_EN
    logic          valid_q, valid_d;
    logic          ovr_q,   ovr_d;
`endif

    assign sclk_s   = sclk_sync_q[SS-1];
    assign cs_s     = cs_sync_q[SS-1];
    assign mosi_s   = mosi_sync_q[SS-1];
    assign sync_vld = vld_sync_q[SS-1];

    // input synchronizers and registered falling-edge / bit capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            fall_q      <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SS-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SS-2:0],   bus.cs};
            mosi_sync_q <= {mosi_sync_q[SS-2:0], bus.mosi};
            vld_sync_q  <= {vld_sync_q[SS-2:0],  1'b1};
            sclk_prev_q <= sclk_s;
            // mosi travels the same depth as sclk, so mosi_s is the bit
            // that was on the line when sclk fell
            fall_q      <= sclk_prev_q & ~sclk_s;
            bit_q       <= mosi_s;
        end
    end

    // FSM and datapath state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            count_q <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            count_q <= count_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef SPI_SLV_OVERRUN_EN
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`endif
        end
    end

    // shift register contents with the current sample inserted at count
    always_comb begin
        word_c = shift_q;
        if (count_q < CW'(DW)) begin
            word_c[count_q[IW-1:0]] = bit_q;
        end
    end

    // next-state, bit collection and frame completion/abort
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        count_d    = count_q;
        shift_d    = shift_q;
        complete_c = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // a frame may only start after cs has been seen high with
                // real pin data in the synchronizer, so a reset in the
                // middle of a frame never resumes that frame
                if (cs_s && sync_vld) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !cs_s) begin
                    state_d = RECV;
                    armed_d = 1'b0;
                    count_d = '0;
                    shift_d = '0;
                end
            end

            RECV: begin
                // cs rise takes priority over a coincident sample
                if (cs_s) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else if (fall_q && (count_q < CW'(DW))) begin
                    shift_d = word_c;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(DW - 1)) begin
                        state_d    = HOLD;
                        complete_c = 1'b1;
                    end
                end
            end

            HOLD: begin
                // sclk is ignored here; wait for the master to release cs
                if (cs_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // output word update; optional read-acknowledge / overrun protection
    always_comb begin
        dout_d = dout_q;
        done_d = 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (bus.rd_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (complete_c) begin
            // an acknowledge in the same clk frees the slot for the new word
            if (valid_q && !bus.rd_ack) begin
                ovr_d = 1'b1;
            end else begin
                dout_d  = word_c;
                done_d  = 1'b1;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end
        end
`else
        if (complete_c) begin
            dout_d = word_c;
            done_d = 1'b1;
        end
`endif
    end

    assign bus.dout      = dout_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.frame_err = ferr_q;
`ifdef SPI_SLV_OVERRUN_EN
    assign bus.valid     = valid_q;
    assign bus.overrun   = ovr_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: self-checking bench for spi_slave_rx.
// A reference model tracks the expected last word and pulse counts from the
// frame rules (full frame -> new word + done, short frame -> frame_err).
module tb_spi_slave_rx;

    localparam int unsigned DW = 12;
    localparam int unsigned SS = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_slave_rx_if #(.DW(DW)) bus ();

    spi_slave_rx #(.DW(DW), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned ferr_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned last_fall_cyc = 0;
    logic [DW-1:0] done_words[$];

    // reference model
    logic [DW-1:0] m_dout = '0;
    int unsigned   m_done = 0;
    int unsigned   m_ferr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                done_words.push_back(bus.dout);
            end
            if (bus.frame_err === 1'b1) ferr_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
`ifdef SPI_SLV_OVERRUN_EN
        bus.rd_ack = 1'b1;
        wait_clks(1);
        bus.rd_ack = 1'b0;
`endif
        wait_clks(1);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int unsigned nbits,
                              input int unsigned half);
        for (int unsigned i = 0; i < nbits; i++) begin
            bus.sclk = 1'b1;
            bus.mosi = w[i];
            wait_clks(half);
            bus.sclk = 1'b0;
            last_fall_cyc = cyc;
            wait_clks(half);
        end
    endtask

    // one cs-framed transfer of nbits bits, then cs high for one sclk period
    task automatic frame(input logic [15:0] w, input int unsigned nbits,
                         input int unsigned half, input bit do_ack);
        if (do_ack) ack_pulse();
        wait_clks(1);
        bus.cs = 1'b0;
        wait_clks(half);
        shift_bits(w, nbits, half);
        bus.cs = 1'b1;
        wait_clks(2 * half);
    endtask

    task automatic model_frame(input logic [15:0] w, input int unsigned nbits);
        if (nbits >= DW) begin
            m_dout = w[DW-1:0];
            m_done++;
        end else begin
            m_ferr++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        checks++; if (bus.dout !== 12'h000) begin errors++; $display("FAIL reset_dout: got %h expected %h", bus.dout, 12'h000); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
        rst_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_basic();
        frame(16'h0A5C, 12, 11, 1'b1);
        model_frame(16'h0A5C, 12);
        checks++; if (bus.dout !== 12'hA5C) begin errors++; $display("FAIL basic_dout: got %h expected %h", bus.dout, 12'hA5C); end
        checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL basic_done_cnt: got %0d expected %0d", done_cnt, m_done); end
        checks++; if (ferr_cnt !== m_ferr) begin errors++; $display("FAIL basic_ferr_cnt: got %0d expected %0d", ferr_cnt, m_ferr); end
        checks++; if (done_cyc - last_fall_cyc !== SS + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", done_cyc - last_fall_cyc, SS + 2); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int unsigned n0;
        n0 = done_words.size();
        frame(16'h0001, 12, 5, 1'b1);
        model_frame(16'h0001, 12);
        frame(16'h0FFF, 12, 5, 1'b1);
        model_frame(16'h0FFF, 12);
        checks++; if (done_words.size() !== n0 + 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected %0d", done_words.size() - n0, 2); end
        if (done_words.size() >= n0 + 2) begin
            checks++; if (done_words[n0] !== 12'h001) begin errors++; $display("FAIL b2b_word0: got %h expected %h", done_words[n0], 12'h001); end
            checks++; if (done_words[n0+1] !== 12'hFFF) begin errors++; $display("FAIL b2b_word1: got %h expected %h", done_words[n0+1], 12'hFFF); end
        end
        checks++; if (bus.dout !== m_dout) begin errors++; $display("FAIL b2b_dout: got %h expected %h", bus.dout, m_dout); end
    endtask

    task automatic test_abort();
        wait_clks(1);
        bus.cs = 1'b0;
        wait_clks(6);
        shift_bits(16'h03C3, 5, 6);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_mid: got %b expected 1", bus.busy); end
        bus.cs = 1'b1;
        wait_clks(12);
        model_frame(16'h03C3, 5);
        checks++; if (ferr_cnt !== m_ferr) begin errors++; $display("FAIL abort_ferr_cnt: got %0d expected %0d", ferr_cnt, m_ferr); end
        checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL abort_done_cnt: got %0d expected %0d", done_cnt, m_done); end
        checks++; if (bus.dout !== m_dout) begin errors++; $display("FAIL abort_dout: got %h expected %h", bus.dout, m_dout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_hold_extra();
        logic [15:0] w;
        w = {4'hB, 12'(($urandom & 32'hFFF) | 32'h001)};
        frame(w, 15, 4, 1'b1);
        model_frame(w, 15);
        checks++; if (bus.dout !== m_dout) begin errors++; $display("FAIL hold_dout: got %h expected %h", bus.dout, m_dout); end
        checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL hold_done_cnt: got %0d expected %0d", done_cnt, m_done); end
        checks++; if (ferr_cnt !== m_ferr) begin errors++; $display("FAIL hold_ferr_cnt: got %0d expected %0d", ferr_cnt, m_ferr); end
    endtask

    task automatic test_reset_midframe();
        wait_clks(1);
        bus.cs = 1'b0;
        wait_clks(5);
        shift_bits(16'($urandom), 6, 5);
        rst_n = 1'b0;
        m_dout = '0;
        wait_clks(2);
        checks++; if (bus.dout !== 12'h000) begin errors++; $display("FAIL rstmid_dout: got %h expected %h", bus.dout, 12'h000); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b expected 0", bus.frame_err); end
        rst_n = 1'b1;
        wait_clks(5);
        // cs still low: a whole frame's worth of clocks must be ignored
        shift_bits(16'h0F0F, 12, 5);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume_busy: got %b expected 0", bus.busy); end
        checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL rstmid_no_resume_done: got %0d expected %0d", done_cnt, m_done); end
        checks++; if (ferr_cnt !== m_ferr) begin errors++; $display("FAIL rstmid_no_resume_ferr: got %0d expected %0d", ferr_cnt, m_ferr); end
        checks++; if (bus.dout !== m_dout) begin errors++; $display("FAIL rstmid_no_resume_dout: got %h expected %h", bus.dout, m_dout); end
        bus.cs = 1'b1;
        wait_clks(10);
        frame(16'h05A5, 12, 5, 1'b1);
        model_frame(16'h05A5, 12);
        checks++; if (bus.dout !== 12'h5A5) begin errors++; $display("FAIL rstmid_new_dout: got %h expected %h", bus.dout, 12'h5A5); end
        checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL rstmid_new_done: got %0d expected %0d", done_cnt, m_done); end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int unsigned nbits;
        int unsigned half;
        for (int unsigned k = 0; k < 24; k++) begin
            w = 16'($urandom);
            nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 11) : $urandom_range(12, 15);
            half = $urandom_range(SS + 2, 9);
            frame(w, nbits, half, 1'b1);
            model_frame(w, nbits);
            checks++; if (bus.dout !== m_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h (nbits %0d)", k, bus.dout, m_dout, nbits); end
            checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL rand_done_cnt[%0d]: got %0d expected %0d", k, done_cnt, m_done); end
            checks++; if (ferr_cnt !== m_ferr) begin errors++; $display("FAIL rand_ferr_cnt[%0d]: got %0d expected %0d", k, ferr_cnt, m_ferr); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected 0", k, bus.busy); end
        end
    endtask

`ifdef SPI_SLV_OVERRUN_EN
    task automatic test_overrun();
        frame(16'h0111, 12, 5, 1'b1);
        model_frame(16'h0111, 12);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_first: got %b expected 1", bus.valid); end
        // second frame without acknowledge: word kept, overrun flagged, no done
        frame(16'h0222, 12, 5, 1'b0);
        checks++; if (bus.dout !== 12'h111) begin errors++; $display("FAIL ovr_dout: got %h expected %h", bus.dout, 12'h111); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_overrun: got %b expected 1", bus.overrun); end
        checks++; if (done_cnt !== m_done) begin errors++; $display("FAIL ovr_done_cnt: got %0d expected %0d", done_cnt, m_done); end
        bus.rd_ack = 1'b1;
        wait_clks(1);
        bus.rd_ack = 1'b0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_ack: got %b expected 0", bus.valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_overrun_ack: got %b expected 0", bus.overrun); end
    endtask
`endif

    initial begin
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
`ifdef SPI_SLV_OVERRUN_EN
        bus.rd_ack = 1'b0;
`endif
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_hold_extra();
        test_reset_midframe();
        test_random();
`ifdef SPI_SLV_OVERRUN_EN
        test_overrun();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
